// File: rtl/reg_dump_unit_pkg.sv
// Shared definitions for the register dump unit: state encodings, index
// width and the helper mapping a word index onto a register address.
package reg_dump_unit_pkg;

    localparam int unsigned DUMP_IDX_W = 6;

    // Word index 0 carries the PC; index k carries x(k-1).
    localparam logic [DUMP_IDX_W-1:0] PC_IDX = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2,
        ST_DONE    = 2'd3
    } dump_state_t;

    // Register-file address for a word index (only meaningful for idx >= 1).
    function automatic logic [4:0] idx_to_raddr(input logic [DUMP_IDX_W-1:0] idx);
        logic [DUMP_IDX_W-1:0] w_dec;
        w_dec = idx - 1'b1;
        return w_dec[4:0];
    endfunction

endpackage

// File: rtl/reg_dump_unit_rise_detect.sv
// Rising-edge detector for the dump request level. The delayed copy resets
// to 0, so a level already high at reset release reads as a rising edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic r_in_q;

    // Delayed copy of the input level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_q <= 1'b0;
        end else begin
            r_in_q <= in;
        end
    end

    assign pulse = in & ~r_in_q;

endmodule

// File: rtl/reg_dump_unit.sv
// Post-run observation stage: on a rising edge of debug it stalls the core,
// snapshots the PC and streams PC followed by x0..x(NREGS-1) over a
// valid/ready word interface, reading registers through a debug read port.
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            debug,
    input  logic [XLEN-1:0] pc_in,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            cpu_stall,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [XLEN-1:0] dump_data,
    output logic [5:0]      dump_idx,
    output logic            dump_last,
    output logic            busy,
    output logic            done
);

    localparam logic [DUMP_IDX_W-1:0] LAST_IDX = DUMP_IDX_W'(NREGS);

    dump_state_t           r_state;
    dump_state_t           w_next_state;
    logic                  w_trigger;
    logic                  w_handshake;
    logic                  w_is_last;
    logic [XLEN-1:0]       r_data;
    logic [DUMP_IDX_W-1:0] r_idx;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst   (rst),
        .in    (debug),
        .pulse (w_trigger)
    );

    assign w_handshake = (r_state == ST_SEND) & dump_ready;
    assign w_is_last   = (r_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; triggers are only honoured in IDLE, never queued.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_CAPTURE: begin
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                if (w_handshake) begin
                    w_next_state = w_is_last ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode from state; data and index come from the datapath registers.
    always_comb begin
        cpu_stall  = 1'b0;
        busy       = 1'b0;
        dump_valid = 1'b0;
        dump_last  = 1'b0;
        done       = 1'b0;
        rf_raddr   = '0;
        case (r_state)
            ST_CAPTURE: begin
                cpu_stall = 1'b1;
                busy      = 1'b1;
                rf_raddr  = idx_to_raddr(r_idx);
            end
            ST_SEND: begin
                cpu_stall  = 1'b1;
                busy       = 1'b1;
                dump_valid = 1'b1;
                dump_last  = w_is_last;
            end
            ST_DONE: begin
                cpu_stall = 1'b1;
                busy      = 1'b1;
                done      = 1'b1;
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

    // Word datapath: PC snapshot on trigger, register capture, index advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_data <= pc_in;
                        r_idx  <= PC_IDX;
                    end
                end
                ST_CAPTURE: begin
                    r_data <= rf_rdata;
                end
                ST_SEND: begin
                    if (w_handshake && !w_is_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign dump_data = r_data;
    assign dump_idx  = r_idx;

endmodule
